ibex_rf_write_arbiter: RTL and testbench

//  Writeback-side arbiter that sits directly upstream of the flop-based register file.

---
 rtl/ibex_rf_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ibex_rf_write_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_write_arbiter.sv
// Writeback arbiter: merges LSU load responses and EX results onto the single RF write port,
// tracks outstanding load destinations and raises operand hazards for ID.
module ibex_rf_write_arbiter #(
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned MaxLoads   = 2,
    parameter int unsigned ExBufDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 ld_issue_i,
    output logic                 ld_ready_o,
    input  logic [4:0]           ld_waddr_i,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o
);
    localparam int unsigned AW     = RV32E ? 4 : 5;
    localparam int unsigned LqIdxW = (MaxLoads > 1) ? $clog2(MaxLoads) : 1;
    localparam int unsigned LqCntW = $clog2(MaxLoads + 1);
    localparam int unsigned EfIdxW = (ExBufDepth > 1) ? $clog2(ExBufDepth) : 1;
    localparam int unsigned EfCntW = $clog2(ExBufDepth + 1);

    function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
        return a[AW-1:0] == b[AW-1:0];
    endfunction

    function automatic logic addr_nz(input logic [4:0] a);
        return |a[AW-1:0];
    endfunction

    function automatic logic [LqIdxW-1:0] lq_inc(input logic [LqIdxW-1:0] p);
        return (p == LqIdxW'(MaxLoads - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [EfIdxW-1:0] ef_inc(input logic [EfIdxW-1:0] p);
        return (p == EfIdxW'(ExBufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Load-destination queue
    logic [4:0]          lq_addr_q [MaxLoads];
    logic [MaxLoads-1:0] lq_vld_q;
    logic [LqIdxW-1:0]   lq_wptr_q, lq_rptr_q;
    logic [LqCntW-1:0]   lq_cnt_q;
    logic                lq_push, lq_pop;
    logic [4:0]          lq_head;

    // EX deferral FIFO
    logic [4:0]           ef_addr_q [ExBufDepth];
    logic [DataWidth-1:0] ef_data_q [ExBufDepth];
    logic [ExBufDepth-1:0] ef_vld_q;
    logic [EfIdxW-1:0]    ef_wptr_q, ef_rptr_q;
    logic [EfCntW-1:0]    ef_cnt_q;
    logic                 ef_push, ef_pop, ef_empty, ef_full;

    logic ex_acc, ex_direct, waw;
    logic [MaxLoads-1:0]   lq_waw, lq_hit_a, lq_hit_b;
    logic [ExBufDepth-1:0] ef_hit_a, ef_hit_b;

    assign lq_head    = lq_addr_q[lq_rptr_q];
    assign ld_ready_o = lq_cnt_q < LqCntW'(MaxLoads);
    assign lq_push    = ld_issue_i & ld_ready_o;
    assign lq_pop     = lsu_rvalid_i & (lq_cnt_q != '0);

    assign ef_empty = ef_cnt_q == '0;
    assign ef_full  = ef_cnt_q == EfCntW'(ExBufDepth);
    assign ef_pop   = ~ef_empty & ~lq_pop;

    always_comb begin
        lq_waw   = '0;
        lq_hit_a = '0;
        lq_hit_b = '0;
        ef_hit_a = '0;
        ef_hit_b = '0;
        for (int i = 0; i < int'(MaxLoads); i++) begin
            lq_waw[i]   = lq_vld_q[i] & addr_eq(lq_addr_q[i], ex_waddr_i);
            lq_hit_a[i] = lq_vld_q[i] & addr_eq(lq_addr_q[i], raddr_a_i);
            lq_hit_b[i] = lq_vld_q[i] & addr_eq(lq_addr_q[i], raddr_b_i);
        end
        for (int i = 0; i < int'(ExBufDepth); i++) begin
            ef_hit_a[i] = ef_vld_q[i] & addr_eq(ef_addr_q[i], raddr_a_i);
            ef_hit_b[i] = ef_vld_q[i] & addr_eq(ef_addr_q[i], raddr_b_i);
        end
    end

    // WAW: an EX write may not land before an older load to the same register
    assign waw        = |lq_waw;
    assign ex_ready_o = ~(ef_full & ~ef_pop) & ~waw;
    assign ex_acc     = ex_valid_i & ex_ready_o;
    assign ef_push    = ex_acc & addr_nz(ex_waddr_i) & (~ef_empty | lq_pop);
    assign ex_direct  = ex_acc & addr_nz(ex_waddr_i) & ef_empty & ~lq_pop;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (lq_pop) begin
            rf_we_o    = ~lsu_err_i & addr_nz(lq_head);
            rf_waddr_o = lq_head;
            rf_wdata_o = lsu_rdata_i;
        end else if (ef_pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ef_addr_q[ef_rptr_q];
            rf_wdata_o = ef_data_q[ef_rptr_q];
        end else if (ex_direct) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end
    end

    assign hazard_o =
        (addr_nz(raddr_a_i) & (|lq_hit_a | |ef_hit_a | (rf_we_o & addr_eq(rf_waddr_o, raddr_a_i)))) |
        (addr_nz(raddr_b_i) & (|lq_hit_b | |ef_hit_b | (rf_we_o & addr_eq(rf_waddr_o, raddr_b_i))));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lq_vld_q  <= '0;
            lq_wptr_q <= '0;
            lq_rptr_q <= '0;
            lq_cnt_q  <= '0;
            ef_vld_q  <= '0;
            ef_wptr_q <= '0;
            ef_rptr_q <= '0;
            ef_cnt_q  <= '0;
        end else begin
            if (lq_push) begin
                lq_vld_q[lq_wptr_q] <= 1'b1;
                lq_wptr_q           <= lq_inc(lq_wptr_q);
            end
            if (lq_pop) begin
                lq_vld_q[lq_rptr_q] <= 1'b0;
                lq_rptr_q           <= lq_inc(lq_rptr_q);
            end
            lq_cnt_q <= lq_cnt_q + LqCntW'(lq_push) - LqCntW'(lq_pop);
            if (ef_pop) begin
                ef_vld_q[ef_rptr_q] <= 1'b0;
                ef_rptr_q           <= ef_inc(ef_rptr_q);
            end
            if (ef_push) begin
                ef_vld_q[ef_wptr_q] <= 1'b1;
                ef_wptr_q           <= ef_inc(ef_wptr_q);
            end
            ef_cnt_q <= ef_cnt_q + EfCntW'(ef_push) - EfCntW'(ef_pop);
        end
    end

    // Payload storage needs no reset; validity is tracked separately
    always_ff @(posedge clk_i) begin
        if (lq_push) lq_addr_q[lq_wptr_q] <= ld_waddr_i;
        if (ef_push) begin
            ef_addr_q[ef_wptr_q] <= ex_waddr_i;
            ef_data_q[ef_wptr_q] <= ex_wdata_i;
        end
    end

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for ibex_rf_write_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_ibex_rf_write_arbiter;
    localparam int DW = 32;
    localparam int ML = 2;
    localparam int ED = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid, ex_ready, ld_issue, ld_ready, lsu_rvalid, lsu_err;
    logic [4:0]    ex_waddr, ld_waddr, raddr_a, raddr_b, rf_waddr;
    logic [DW-1:0] ex_wdata, lsu_rdata, rf_wdata;
    logic          hazard, rf_we;

    always #5 clk = ~clk;

    ibex_rf_write_arbiter #(.RV32E(1'b0), .DataWidth(DW), .MaxLoads(ML), .ExBufDepth(ED)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .ld_issue_i(ld_issue), .ld_ready_o(ld_ready), .ld_waddr_i(ld_waddr),
        .lsu_rvalid_i(lsu_rvalid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_o(hazard),
        .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we)
    );

    typedef struct { logic [4:0] a; logic [DW-1:0] d; } ent_t;
    logic [4:0] m_lq[$];
    ent_t       m_ef[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic          e_we, e_hz, e_exr, e_ldr, m_ldslot, m_efpop, m_acc, m_buf;
    logic [4:0]    e_wa;
    logic [DW-1:0] e_wd;

    function automatic logic in_lq(input logic [4:0] r);
        foreach (m_lq[i]) if (m_lq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic in_ef(input logic [4:0] r);
        foreach (m_ef[i]) if (m_ef[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic hz(input logic [4:0] r);
        return (r != 0) && (in_lq(r) || in_ef(r) || (e_we && e_wa == r));
    endfunction

    // Expected outputs from the queue contents and the current inputs
    function automatic void model_eval();
        e_ldr    = m_lq.size() < ML;
        m_ldslot = lsu_rvalid && m_lq.size() != 0;
        m_efpop  = m_ef.size() != 0 && !m_ldslot;
        e_exr    = !(m_ef.size() == ED && !m_efpop) && !in_lq(ex_waddr);
        m_acc    = ex_valid && e_exr;
        e_we = 1'b0; e_wa = '0; e_wd = '0;
        if (m_ldslot) begin
            e_we = !lsu_err && m_lq[0] != 0; e_wa = m_lq[0]; e_wd = lsu_rdata;
        end else if (m_efpop) begin
            e_we = 1'b1; e_wa = m_ef[0].a; e_wd = m_ef[0].d;
        end else if (m_acc && ex_waddr != 0) begin
            e_we = 1'b1; e_wa = ex_waddr; e_wd = ex_wdata;
        end
        m_buf = m_acc && ex_waddr != 0 && (m_ldslot || m_ef.size() != 0);
        e_hz  = hz(raddr_a) || hz(raddr_b);
    endfunction

    always @(negedge clk) begin
        #2;
        model_eval();
        vectors++;
        if (rf_we !== e_we || hazard !== e_hz || ex_ready !== e_exr || ld_ready !== e_ldr ||
            (e_we && (rf_waddr !== e_wa || rf_wdata !== e_wd))) begin
            miscompares++;
            $display("FAIL cycle %0d model: got we=%b wa=%0d wd=%h hz=%b exr=%b ldr=%b expected we=%b wa=%0d wd=%h hz=%b exr=%b ldr=%b",
                     cyc, rf_we, rf_waddr, rf_wdata, hazard, ex_ready, ld_ready,
                     e_we, e_wa, e_wd, e_hz, e_exr, e_ldr);
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            model_eval();
            if (m_ldslot) void'(m_lq.pop_front());
            if (m_efpop) void'(m_ef.pop_front());
            if (m_buf) m_ef.push_back('{ex_waddr, ex_wdata});
            if (ld_issue && e_ldr) m_lq.push_back(ld_waddr);
        end
    end

    always @(negedge rst_n) begin
        m_lq.delete();
        m_ef.delete();
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0; ld_issue = 0; ld_waddr = 0;
        lsu_rvalid = 0; lsu_rdata = 0; lsu_err = 0; raddr_a = 0; raddr_b = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0; ld_issue = 0; ld_waddr = 0;
        lsu_rvalid = 0; lsu_rdata = 0; lsu_err = 0; raddr_a = 0; raddr_b = 0;
        #2;
        lit("reset rf_we", rf_we, 0);
        lit("reset rf_waddr", rf_waddr, 0);
        lit("reset rf_wdata", rf_wdata, 0);
        lit("reset hazard", hazard, 0);
        lit("reset ex_ready", ex_ready, 1);
        lit("reset ld_ready", ld_ready, 1);
        #10 rst_n = 1'b1;

        // direct zero-latency EX write
        nxt(); ex_valid = 1; ex_waddr = 5; ex_wdata = 32'hA5A5; #3;
        lit("direct we", rf_we, 1); lit("direct waddr", rf_waddr, 5); lit("direct wdata", rf_wdata, 32'hA5A5);

        // load hazard and response
        nxt(); ld_issue = 1; ld_waddr = 7;
        nxt(); raddr_a = 7; #3; lit("load pending hazard", hazard, 1);
        nxt(); raddr_a = 7; lsu_rvalid = 1; lsu_rdata = 32'h1234; #3;
        lit("load resp we", rf_we, 1); lit("load resp waddr", rf_waddr, 7);
        lit("load resp wdata", rf_wdata, 32'h1234); lit("load write-cycle hazard", hazard, 1);
        nxt(); raddr_a = 7; #3; lit("load hazard cleared", hazard, 0);

        // collision: load x3 vs EX x4, then EX x6
        nxt(); ld_issue = 1; ld_waddr = 3;
        nxt(); lsu_rvalid = 1; lsu_rdata = 32'h3333; ex_valid = 1; ex_waddr = 4; ex_wdata = 32'h55; #3;
        lit("collide c0 waddr", rf_waddr, 3); lit("collide c0 ex_ready", ex_ready, 1);
        nxt(); ex_valid = 1; ex_waddr = 6; ex_wdata = 32'h66; #3;
        lit("collide c1 waddr", rf_waddr, 4); lit("collide c1 wdata", rf_wdata, 32'h55);
        nxt(); #3; lit("collide c2 waddr", rf_waddr, 6); lit("collide c2 wdata", rf_wdata, 32'h66);
        nxt(); #3; lit("collide idle we", rf_we, 0);

        // fill FIFO behind back-to-back responses
        nxt(); ld_issue = 1; ld_waddr = 10;
        nxt(); ld_issue = 1; ld_waddr = 11;
        nxt(); lsu_rvalid = 1; ex_valid = 1; ex_waddr = 12; ex_wdata = 32'hC; #3;
        lit("fill ld_ready full", ld_ready, 0); lit("fill c0 waddr", rf_waddr, 10);
        nxt(); lsu_rvalid = 1; ld_issue = 1; ld_waddr = 13; ex_valid = 1; ex_waddr = 14; ex_wdata = 32'hE; #3;
        lit("fill c1 waddr", rf_waddr, 11); lit("fill c1 ld_ready", ld_ready, 1);
        nxt(); lsu_rvalid = 1; ex_valid = 1; ex_waddr = 15; ex_wdata = 32'hF; #3;
        lit("fill c2 waddr", rf_waddr, 13); lit("fill c2 ex_ready", ex_ready, 0);
        nxt(); ex_valid = 1; ex_waddr = 15; ex_wdata = 32'hF; #3;
        lit("drain c0 ex_ready", ex_ready, 1); lit("drain c0 waddr", rf_waddr, 12); lit("drain c0 wdata", rf_wdata, 32'hC);
        nxt(); #3; lit("drain c1 waddr", rf_waddr, 14); lit("drain c1 wdata", rf_wdata, 32'hE);
        nxt(); #3; lit("drain c2 waddr", rf_waddr, 15); lit("drain c2 wdata", rf_wdata, 32'hF);
        nxt(); #3; lit("drain idle we", rf_we, 0);

        // bus error on x9
        nxt(); ld_issue = 1; ld_waddr = 9;
        nxt(); raddr_a = 9; #3; lit("err pending hazard", hazard, 1);
        nxt(); raddr_a = 9; lsu_rvalid = 1; lsu_err = 1; ex_valid = 1; ex_waddr = 9; #3;
        lit("err we", rf_we, 0); lit("err waw ex_ready", ex_ready, 0);
        nxt(); ex_valid = 1; ex_waddr = 9; ex_wdata = 32'h99; #3;
        lit("err next ex_ready", ex_ready, 1); lit("err next we", rf_we, 1); lit("err next waddr", rf_waddr, 9);
        nxt(); raddr_a = 9; #3; lit("err hazard cleared", hazard, 0);

        // queue full, issue+respond same cycle, spurious response
        nxt(); ld_issue = 1; ld_waddr = 1;
        nxt(); ld_issue = 1; ld_waddr = 2;
        nxt(); ld_issue = 1; ld_waddr = 3; lsu_rvalid = 1; lsu_rdata = 32'h11; #3;
        lit("full ld_ready", ld_ready, 0); lit("full resp waddr", rf_waddr, 1);
        nxt(); lsu_rvalid = 1; lsu_rdata = 32'h22; #3;
        lit("after pop ld_ready", ld_ready, 1); lit("second resp waddr", rf_waddr, 2);
        nxt(); lsu_rvalid = 1; lsu_rdata = 32'hDEAD; #3; lit("spurious resp we", rf_we, 0);

        // async reset mid-operation
        nxt(); ld_issue = 1; ld_waddr = 5;
        nxt(); raddr_a = 5; #1; lit("pre-reset hazard", hazard, 1);
        rst_n = 1'b0; #1; lit("reset flush hazard", hazard, 0);
        nxt(); rst_n = 1'b1;
        nxt(); lsu_rvalid = 1; lsu_rdata = 32'h77; #3; lit("post-reset resp we", rf_we, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            nxt();
            if ($urandom_range(0, 499) == 0) begin
                #4 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                ex_valid   = $urandom_range(0, 99) < 60;
                ex_waddr   = 5'($urandom_range(0, 7));
                ex_wdata   = $urandom;
                ld_issue   = $urandom_range(0, 99) < 40;
                ld_waddr   = 5'($urandom_range(0, 7));
                lsu_rvalid = $urandom_range(0, 99) < 45;
                lsu_rdata  = $urandom;
                lsu_err    = $urandom_range(0, 99) < 10;
                raddr_a    = 5'($urandom_range(0, 7));
                raddr_b    = 5'($urandom_range(0, 7));
            end
        end
        nxt(); #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
